// File: rtl/wfg_interconnect_xbar_if.sv
// Bus bundle for the wfg stimulus-to-driver crossbar: Wishbone slave port,
// NUM_STIM AXI-stream sinks and NUM_DRV AXI-stream sources.
//
// Handshake: a stream beat moves on a rising clock edge where tvalid and
// tready are both high; tvalid/tdata are held stable while tready is low, and
// no driver-side tvalid ever waits on its own tready. A Wishbone access is
// stb&cyc held until a one-cycle ack.
interface wfg_interconnect_xbar_if #(
    parameter int BUSW            = 32,
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int NUM_STIM        = 4,
    parameter int NUM_DRV         = 4
);
    logic                                wbs_stb_i;
    logic                                wbs_cyc_i;
    logic                                wbs_we_i;
    logic [3:0]                          wbs_sel_i;
    logic [BUSW-1:0]                     wbs_adr_i;
    logic [BUSW-1:0]                     wbs_dat_i;
    logic                                wbs_ack_o;
    logic [BUSW-1:0]                     wbs_dat_o;
    logic [NUM_STIM-1:0]                 stim_tvalid_i;
    logic [NUM_STIM*AXIS_DATA_WIDTH-1:0] stim_tdata_i;
    logic [NUM_STIM-1:0]                 stim_tready_o;
    logic [NUM_DRV-1:0]                  drv_tvalid_o;
    logic [NUM_DRV*AXIS_DATA_WIDTH-1:0]  drv_tdata_o;
    logic [NUM_DRV-1:0]                  drv_tready_i;

    // Crossbar side.
    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        input  stim_tvalid_i, stim_tdata_i,
        output stim_tready_o,
        output drv_tvalid_o, drv_tdata_o,
        input  drv_tready_i
    );

    // Bus master / stream environment side.
    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        output stim_tvalid_i, stim_tdata_i,
        input  stim_tready_o,
        input  drv_tvalid_o, drv_tdata_o,
        output drv_tready_i
    );
endinterface

// File: rtl/wfg_interconnect_xbar.sv
// Wishbone-configured crossbar routing NUM_STIM stimulus streams to NUM_DRV
// driver streams. Each driver has a one-entry output register; a source may
// fan out to several drivers and only advances when all of them can take it.
module wfg_interconnect_xbar #(
    parameter int BUSW            = 32,
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int NUM_STIM        = 4,
    parameter int NUM_DRV         = 4
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    wfg_interconnect_xbar_if.slave   bus
);
    localparam int W = AXIS_DATA_WIDTH;

    // Configuration state.
    logic                 en;
    logic [7:0]           sel [NUM_DRV];

    // Wishbone slave state.
    logic                 ack;
    logic [BUSW-1:0]      dat_out;
    logic                 wb_hit;
    logic [5:0]           wb_idx;
    logic [BUSW-1:0]      rd_data;

    // Driver output registers.
    logic [NUM_DRV-1:0]   drv_vld;
    logic [NUM_DRV*W-1:0] drv_data;

    // Routing terms.
    logic [NUM_DRV-1:0]   mapped;
    logic [NUM_DRV-1:0]   slot_free;
    logic [NUM_DRV-1:0]   load;
    logic [NUM_DRV*W-1:0] load_data;
    logic [NUM_STIM-1:0]  src_used;
    logic [NUM_STIM-1:0]  src_free;
    logic [NUM_STIM-1:0]  tready;

    // Byte lanes, word offset and high address/data bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{bus.wbs_sel_i, bus.wbs_adr_i[BUSW-1:8], bus.wbs_adr_i[1:0],
                           bus.wbs_dat_i[BUSW-1:8]};

    // A new access is accepted only while ack is low, giving ack every other cycle.
    assign wb_hit = bus.wbs_stb_i & bus.wbs_cyc_i & ~ack;
    assign wb_idx = bus.wbs_adr_i[7:2];

    // Read mux over the register map; unmapped words read as zero.
    always_comb begin
        rd_data = '0;
        if (wb_idx == 6'd0) begin
            rd_data[0] = en;
        end else if (wb_idx == 6'd1) begin
            rd_data[NUM_DRV-1:0] = drv_vld;
        end
        for (int d = 0; d < NUM_DRV; d++) begin
            if (wb_idx == 6'(2 + d)) begin
                rd_data[7:0] = sel[d];
            end
        end
    end

    // Ack one cycle after the access is seen; read data only during ack.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack     <= 1'b0;
            dat_out <= '0;
        end else begin
            ack     <= wb_hit;
            dat_out <= (wb_hit && !bus.wbs_we_i) ? rd_data : '0;
        end
    end

    // Register writes take effect on the same edge that raises ack, so the
    // new configuration is already in force during the ack cycle.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            en <= 1'b0;
            for (int d = 0; d < NUM_DRV; d++) begin
                sel[d] <= 8'(d);
            end
        end else if (wb_hit && bus.wbs_we_i) begin
            if (wb_idx == 6'd0) begin
                en <= bus.wbs_dat_i[0];
            end
            for (int d = 0; d < NUM_DRV; d++) begin
                if (wb_idx == 6'(2 + d)) begin
                    sel[d] <= bus.wbs_dat_i[7:0];
                end
            end
        end
    end

    // Per-driver mapping and slot availability.
    always_comb begin
        for (int d = 0; d < NUM_DRV; d++) begin
            mapped[d]    = ({24'd0, sel[d]} < 32'(NUM_STIM));
            slot_free[d] = ~drv_vld[d] | bus.drv_tready_i[d];
        end
    end

    // A source is ready only when selected and every driver selecting it is free.
    always_comb begin
        for (int s = 0; s < NUM_STIM; s++) begin
            src_used[s] = 1'b0;
            src_free[s] = 1'b1;
            for (int d = 0; d < NUM_DRV; d++) begin
                if (mapped[d] && sel[d] == 8'(s)) begin
                    src_used[s] = 1'b1;
                    src_free[s] = src_free[s] & slot_free[d];
                end
            end
            tready[s] = en & src_used[s] & src_free[s];
        end
    end

    // Each mapped driver picks up its source's beat whenever that source transfers.
    always_comb begin
        load      = '0;
        load_data = '0;
        for (int d = 0; d < NUM_DRV; d++) begin
            for (int s = 0; s < NUM_STIM; s++) begin
                if (sel[d] == 8'(s)) begin
                    load[d]            = bus.stim_tvalid_i[s] & tready[s];
                    load_data[d*W +: W] = bus.stim_tdata_i[s*W +: W];
                end
            end
        end
    end

    // Driver registers: a load wins over a consume; a consume alone clears valid
    // and leaves the data in place.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            drv_vld  <= '0;
            drv_data <= '0;
        end else begin
            for (int d = 0; d < NUM_DRV; d++) begin
                if (load[d]) begin
                    drv_vld[d]         <= 1'b1;
                    drv_data[d*W +: W] <= load_data[d*W +: W];
                end else if (bus.drv_tready_i[d]) begin
                    drv_vld[d] <= 1'b0;
                end
            end
        end
    end

    assign bus.wbs_ack_o     = ack;
    assign bus.wbs_dat_o     = dat_out;
    assign bus.stim_tready_o = tready;
    assign bus.drv_tvalid_o  = drv_vld;
    assign bus.drv_tdata_o   = drv_data;
endmodule
